// File: rtl/npu_bias_pkg.sv
// ---------------------------------------------------------------------------
// npu_bias_pkg
// Shared definitions for the bias scheduler slice: the bias word width and
// the scheduler FSM state encoding.
// ---------------------------------------------------------------------------
package npu_bias_pkg;

   localparam int unsigned BIAS_W = 512;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } bias_state_e;

endpackage

// File: rtl/bias_pf_fifo.sv
// ---------------------------------------------------------------------------
// bias_pf_fifo
// Synchronous prefetch FIFO, DEPTH x BIAS_W, head visible combinationally.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_clr          synchronous clear of pointers/count
//   i_push, i_din  write one word (ignored when full)
//   i_pop          drop the head word (ignored when empty)
//   o_head         current head word
//   o_full/o_empty status, o_count occupancy
// ---------------------------------------------------------------------------
module bias_pf_fifo
   import npu_bias_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_clr,
   input  logic                     i_push,
   input  logic [BIAS_W-1:0]        i_din,
   input  logic                     i_pop,
   output logic [BIAS_W-1:0]        o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [BIAS_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     cnt;
   logic              do_push;
   logic              do_pop;

   assign o_full  = (cnt == CW'(DEPTH));
   assign o_empty = (cnt == '0);
   assign o_count = cnt;
   assign o_head  = mem[rd_ptr];

   assign do_push = i_push & ~o_full;
   assign do_pop  = i_pop & ~o_empty;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push && !i_clr) mem[wr_ptr] <= i_din;
   end

endmodule

// File: rtl/bias_sched.sv
// ---------------------------------------------------------------------------
// bias_sched
// Prefetches bias words from the bias RAM into a small FIFO and presents
// one word per NPE output beat; each word serves i_part_num beats, for
// i_output_layers groups.
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_calc_en / i_calculate_end       start / abort pulses
//   i_addr_start_b, i_output_layers,
//   i_part_num                        job configuration (latched on start)
//   i_npe_dat_vld                     one NPE beat consuming the bias word
//   o_ram_addr, o_ram_rd_en,
//   i_ram_dat_vld, i_ram_dat          bias RAM read port (in-order returns)
//   o_bias_dat, o_bias_vld            bias word aligned to the NPE beat
//   o_busy, o_done, o_underflow,
//   o_stall_cnt                       status
// Build option: define BIAS_SCHED_STATS_EN to count underflow beats in
// o_stall_cnt; otherwise o_stall_cnt is tied to zero.
// ---------------------------------------------------------------------------
module bias_sched
   import npu_bias_pkg::*;
#(
   parameter int unsigned RAM_ADDR_WIDTH = 8,
   parameter int unsigned PF_DEPTH       = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_calc_en,
   input  logic                      i_calculate_end,
   input  logic [RAM_ADDR_WIDTH-1:0] i_addr_start_b,
   input  logic [7:0]                i_output_layers,
   input  logic [7:0]                i_part_num,
   input  logic                      i_npe_dat_vld,
   output logic [RAM_ADDR_WIDTH-1:0] o_ram_addr,
   output logic                      o_ram_rd_en,
   input  logic                      i_ram_dat_vld,
   input  logic [BIAS_W-1:0]         i_ram_dat,
   output logic [BIAS_W-1:0]         o_bias_dat,
   output logic                      o_bias_vld,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_underflow,
   output logic [15:0]               o_stall_cnt
);

   localparam int unsigned CW = $clog2(PF_DEPTH) + 1;

   bias_state_e               state_q, state_d;
   logic [7:0]                layers_q, part_q;
   logic [RAM_ADDR_WIDTH-1:0] rd_addr_q;
   logic [7:0]                issued_q, group_q, part_cnt_q;
   logic [CW-1:0]             out_q, out_after_ret;

   logic [BIAS_W-1:0]         head;
   logic                      full, empty;
   logic [CW-1:0]             count;

   logic accept, cfg_ok, abort, ret, push, beat, serve, miss;
   logic last_part, last_group, pop, issue, fifo_clr;

   // Outstanding reads are counted from the cycle the read is decided,
   // so count+outstanding never exceeds PF_DEPTH and a return always fits.
   always_comb begin
      accept        = (state_q == S_IDLE) && i_calc_en;
      cfg_ok        = (i_output_layers != '0) && (i_part_num != '0);
      abort         = (state_q == S_RUN) && i_calculate_end;
      ret           = i_ram_dat_vld && (out_q != '0) &&
                      ((state_q == S_RUN) || (state_q == S_FLUSH));
      out_after_ret = out_q - CW'(ret);
      push          = ret && (state_q == S_RUN) && !abort && !full;
      beat          = (state_q == S_RUN) && i_npe_dat_vld && !abort;
      serve         = beat && !empty;
      miss          = beat && empty;
      last_part     = (part_cnt_q == part_q - 8'd1);
      last_group    = (group_q == layers_q - 8'd1);
      pop           = serve && last_part;
      issue         = (state_q == S_RUN) && !abort && (issued_q < layers_q) &&
                      (({1'b0, count} + {1'b0, out_q}) < (CW + 1)'(PF_DEPTH));
      fifo_clr      = accept || abort;

      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = cfg_ok ? S_RUN : S_DONE;
         S_RUN: begin
            if (abort)                  state_d = (out_after_ret != '0) ? S_FLUSH : S_IDLE;
            else if (pop && last_group) state_d = S_DONE;
         end
         S_FLUSH: if (out_after_ret == '0) state_d = S_IDLE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   assign o_busy = (state_q == S_RUN) || (state_q == S_FLUSH);
   assign o_done = (state_q == S_DONE);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         layers_q    <= '0;
         part_q      <= '0;
         rd_addr_q   <= '0;
         issued_q    <= '0;
         group_q     <= '0;
         part_cnt_q  <= '0;
         out_q       <= '0;
         o_ram_addr  <= '0;
         o_ram_rd_en <= 1'b0;
         o_bias_dat  <= '0;
         o_bias_vld  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         o_ram_rd_en <= issue;
         o_bias_vld  <= serve;
         out_q       <= out_after_ret + CW'(issue);
         if (serve) o_bias_dat <= head;
         if (issue) begin
            o_ram_addr <= rd_addr_q;
            rd_addr_q  <= rd_addr_q + 1'b1;
            issued_q   <= issued_q + 8'd1;
         end
         if (accept) begin
            layers_q    <= i_output_layers;
            part_q      <= i_part_num;
            rd_addr_q   <= i_addr_start_b;
            issued_q    <= '0;
            group_q     <= '0;
            part_cnt_q  <= '0;
            o_underflow <= 1'b0;
         end else begin
            if (miss) o_underflow <= 1'b1;
            if (serve) begin
               if (last_part) begin
                  part_cnt_q <= '0;
                  group_q    <= group_q + 8'd1;
               end else begin
                  part_cnt_q <= part_cnt_q + 8'd1;
               end
            end
         end
      end
   end

   bias_pf_fifo #(
      .DEPTH (PF_DEPTH)
   ) u_pf_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (fifo_clr),
      .i_push  (push),
      .i_din   (i_ram_dat),
      .i_pop   (pop),
      .o_head  (head),
      .o_full  (full),
      .o_empty (empty),
      .o_count (count)
   );

`ifdef BIAS_SCHED_STATS_EN
   logic [15:0] stall_q;

   always_ff @(posedge i_clk) begin
      if (i_rst)                       stall_q <= '0;
      else if (accept)                 stall_q <= '0;
      else if (miss && stall_q != '1)  stall_q <= stall_q + 16'd1;
   end

   assign o_stall_cnt = stall_q;
`else
   assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_bias_sched.sv
module tb_bias_sched;
   import npu_bias_pkg::*;

   logic             clk;
   logic             rst;
   logic             calc_en, calc_end;
   logic [7:0]       addr_start, layers, part;
   logic             npe_vld;
   logic [7:0]       ram_addr;
   logic             ram_rd_en;
   logic             ram_vld;
   logic [511:0]     ram_dat;
   logic [511:0]     bias_dat;
   logic             bias_vld, busy, done, underflow;
   logic [15:0]      stall_cnt;

   int               n_tests = 0;
   int               n_fail  = 0;
   int               done_cnt = 0;
   int               lat = 2;
   int               ncyc = 0;
   int               d0;

   logic [7:0]       exp_addr [$];
   logic [511:0]     exp_bias [$];
   logic [7:0]       rq_addr  [$];
   int               rq_due   [$];

   bias_sched #(
      .RAM_ADDR_WIDTH (8),
      .PF_DEPTH       (4)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_calc_en       (calc_en),
      .i_calculate_end (calc_end),
      .i_addr_start_b  (addr_start),
      .i_output_layers (layers),
      .i_part_num      (part),
      .i_npe_dat_vld   (npe_vld),
      .o_ram_addr      (ram_addr),
      .o_ram_rd_en     (ram_rd_en),
      .i_ram_dat_vld   (ram_vld),
      .i_ram_dat       (ram_dat),
      .o_bias_dat      (bias_dat),
      .o_bias_vld      (bias_vld),
      .o_busy          (busy),
      .o_done          (done),
      .o_underflow     (underflow),
      .o_stall_cnt     (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [511:0] wfun(input logic [7:0] a);
      return {16{24'hB1A5C0, a}};
   endfunction

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic start(input logic [7:0] a, input logic [7:0] l, input logic [7:0] p);
      addr_start = a;
      layers     = l;
      part       = p;
      calc_en    = 1'b1;
      tick();
      calc_en    = 1'b0;
   endtask

   // RAM model: a read seen at negedge k returns data held across posedge k+lat.
   always @(negedge clk) begin
      if (ram_rd_en) begin
         rq_addr.push_back(ram_addr);
         rq_due.push_back(ncyc + lat - 1);
      end
      if (rq_due.size() != 0 && rq_due[0] == ncyc) begin
         ram_vld = 1'b1;
         ram_dat = wfun(rq_addr.pop_front());
         void'(rq_due.pop_front());
      end else begin
         ram_vld = 1'b0;
         ram_dat = '0;
      end
      ncyc++;
   end

   // Monitor: compare every read address and every bias beat with the scoreboard.
   always @(negedge clk) begin
      if (ram_rd_en) begin
         if (exp_addr.size() == 0) chk("unexpected_read", {504'd0, ram_addr}, 512'h1FF);
         else                      chk("ram_addr", {504'd0, ram_addr}, {504'd0, exp_addr.pop_front()});
      end
      if (bias_vld) begin
         if (exp_bias.size() == 0) chk("unexpected_bias", bias_dat, '1);
         else                      chk("bias_word", bias_dat, exp_bias.pop_front());
      end
      if (done) done_cnt++;
   end

   initial begin
      rst = 1'b1; calc_en = 1'b0; calc_end = 1'b0; npe_vld = 1'b0;
      addr_start = '0; layers = '0; part = '0;
      repeat (3) tick();
      chk("rst_busy", {511'd0, busy}, 512'd0);
      chk("rst_done", {511'd0, done}, 512'd0);
      chk("rst_rd_en", {511'd0, ram_rd_en}, 512'd0);
      chk("rst_bias_vld", {511'd0, bias_vld}, 512'd0);
      rst = 1'b0;
      tick();

      // Basic: 3 groups, 2 beats each, latency 2
      lat = 2;
      exp_addr.push_back(8'h10); exp_addr.push_back(8'h11); exp_addr.push_back(8'h12);
      foreach (exp_addr[i]) begin
         exp_bias.push_back(wfun(exp_addr[i]));
         exp_bias.push_back(wfun(exp_addr[i]));
      end
      d0 = done_cnt;
      start(8'h10, 8'd3, 8'd2);
      repeat (10) tick();
      npe_vld = 1'b1;
      repeat (6) tick();
      npe_vld = 1'b0;
      repeat (3) tick();
      chk("t1_done_once", 512'(done_cnt - d0), 512'd1);
      chk("t1_idle", {511'd0, busy}, 512'd0);
      chk("t1_addr_q_empty", 512'(exp_addr.size()), 512'd0);
      chk("t1_bias_q_empty", 512'(exp_bias.size()), 512'd0);

      // Address wrap: FE, FF, 00, 01, latency 1
      lat = 1;
      exp_addr.push_back(8'hFE); exp_addr.push_back(8'hFF);
      exp_addr.push_back(8'h00); exp_addr.push_back(8'h01);
      foreach (exp_addr[i]) exp_bias.push_back(wfun(exp_addr[i]));
      d0 = done_cnt;
      start(8'hFE, 8'd4, 8'd1);
      repeat (8) tick();
      npe_vld = 1'b1;
      repeat (4) tick();
      npe_vld = 1'b0;
      repeat (3) tick();
      chk("t2_done_once", 512'(done_cnt - d0), 512'd1);
      chk("t2_addr_q_empty", 512'(exp_addr.size()), 512'd0);
      chk("t2_bias_q_empty", 512'(exp_bias.size()), 512'd0);

      // Zero layers and zero parts go straight to DONE without reads
      calc_en = 1'b1; layers = 8'd0; part = 8'd2;
      tick();
      calc_en = 1'b0;
      chk("zl_done", {511'd0, done}, 512'd1);
      chk("zl_busy", {511'd0, busy}, 512'd0);
      tick();
      chk("zl_done_drop", {511'd0, done}, 512'd0);
      calc_en = 1'b1; layers = 8'd2; part = 8'd0;
      tick();
      calc_en = 1'b0;
      chk("zp_done", {511'd0, done}, 512'd1);
      repeat (4) tick();

      // Underflow: beats from the cycle after start, latency 5 -> 6 missed beats
      lat = 5;
      exp_addr.push_back(8'h20); exp_addr.push_back(8'h21);
      exp_bias.push_back(wfun(8'h20)); exp_bias.push_back(wfun(8'h20));
      exp_bias.push_back(wfun(8'h21)); exp_bias.push_back(wfun(8'h21));
      d0 = done_cnt;
      start(8'h20, 8'd2, 8'd2);
      npe_vld = 1'b1;
      repeat (10) tick();
      npe_vld = 1'b0;
      repeat (3) tick();
      chk("uf_flag", {511'd0, underflow}, 512'd1);
`ifdef BIAS_SCHED_STATS_EN
      chk("uf_stall_cnt", {496'd0, stall_cnt}, 512'd6);
`else
      chk("uf_stall_cnt", {496'd0, stall_cnt}, 512'd0);
`endif
      chk("uf_done_once", 512'(done_cnt - d0), 512'd1);
      chk("uf_bias_q_empty", 512'(exp_bias.size()), 512'd0);

      // Abort with two reads outstanding
      lat = 6;
      exp_addr.push_back(8'h30); exp_addr.push_back(8'h31);
      d0 = done_cnt;
      start(8'h30, 8'd4, 8'd1);
      chk("ab_uf_cleared", {511'd0, underflow}, 512'd0);
      chk("ab_stall_cleared", {496'd0, stall_cnt}, 512'd0);
      tick();
      tick();
      calc_end = 1'b1;
      tick();
      calc_end = 1'b0;
      chk("ab_flush_busy", {511'd0, busy}, 512'd1);
      repeat (5) tick();
      chk("ab_idle", {511'd0, busy}, 512'd0);
      chk("ab_no_done", 512'(done_cnt - d0), 512'd0);
      chk("ab_addr_q_empty", 512'(exp_addr.size()), 512'd0);

      // Clean run after abort
      lat = 2;
      exp_addr.push_back(8'h40); exp_addr.push_back(8'h41);
      exp_bias.push_back(wfun(8'h40)); exp_bias.push_back(wfun(8'h41));
      d0 = done_cnt;
      start(8'h40, 8'd2, 8'd1);
      repeat (6) tick();
      npe_vld = 1'b1;
      repeat (2) tick();
      npe_vld = 1'b0;
      repeat (3) tick();
      chk("re_done_once", 512'(done_cnt - d0), 512'd1);
      chk("re_bias_q_empty", 512'(exp_bias.size()), 512'd0);

      // Reset in the middle of RUN
      lat = 3;
      exp_addr.push_back(8'h50); exp_addr.push_back(8'h51); exp_addr.push_back(8'h52);
      exp_bias.push_back(wfun(8'h50));
      d0 = done_cnt;
      start(8'h50, 8'd3, 8'd1);
      repeat (4) tick();
      npe_vld = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      chk("mr_bias_vld", {511'd0, bias_vld}, 512'd0);
      chk("mr_bias_dat", bias_dat, 512'd0);
      chk("mr_busy", {511'd0, busy}, 512'd0);
      chk("mr_rd_en", {511'd0, ram_rd_en}, 512'd0);
      chk("mr_addr", {504'd0, ram_addr}, 512'd0);
      chk("mr_underflow", {511'd0, underflow}, 512'd0);
      chk("mr_stall", {496'd0, stall_cnt}, 512'd0);
      rst = 1'b0;
      npe_vld = 1'b0;
      repeat (4) tick();
      chk("mr_no_done", 512'(done_cnt - d0), 512'd0);
      chk("mr_still_idle", {511'd0, busy}, 512'd0);

      // Run after reset: one group of three beats
      lat = 1;
      exp_addr.push_back(8'h60);
      repeat (3) exp_bias.push_back(wfun(8'h60));
      d0 = done_cnt;
      start(8'h60, 8'd1, 8'd3);
      repeat (5) tick();
      npe_vld = 1'b1;
      repeat (3) tick();
      npe_vld = 1'b0;
      repeat (3) tick();
      chk("pr_done_once", 512'(done_cnt - d0), 512'd1);
      chk("pr_underflow", {511'd0, underflow}, 512'd0);
      chk("pr_addr_q_empty", 512'(exp_addr.size()), 512'd0);
      chk("pr_bias_q_empty", 512'(exp_bias.size()), 512'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
